// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO bank.
//   - Register byte offsets within the 64-byte block (bits [1:0] are ignored by the decoder).
//   - Legal pin-count range and a helper that checks a candidate width against it.
package gpio_pkg;

    typedef logic [5:0] gpio_offset_t;

    localparam gpio_offset_t GPIO_DATA_IN    = 6'h00;
    localparam gpio_offset_t GPIO_DATA_OUT   = 6'h04;
    localparam gpio_offset_t GPIO_OUT_SET    = 6'h08;
    localparam gpio_offset_t GPIO_OUT_CLR    = 6'h0C;
    localparam gpio_offset_t GPIO_OUT_TGL    = 6'h10;
    localparam gpio_offset_t GPIO_DIR        = 6'h14;
    localparam gpio_offset_t GPIO_RISE_EN    = 6'h18;
    localparam gpio_offset_t GPIO_FALL_EN    = 6'h1C;
    localparam gpio_offset_t GPIO_IRQ_STATUS = 6'h20;

    localparam int unsigned GPIO_WIDTH_MIN = 1;
    localparam int unsigned GPIO_WIDTH_MAX = 32;

    function automatic bit gpio_width_legal(input int unsigned width);
        return (width >= GPIO_WIDTH_MIN) && (width <= GPIO_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// gpio_bank_if: data-memory bus slice seen by the GPIO bank.
//   MemWrite - write strobe, one cycle per access
//   MemRead  - read strobe; rdata is valid while it is high
//   addr     - byte offset within the block
//   wdata    - write data
//   rdata    - combinational read data, 0 when MemRead is low
// master = datapath side, slave = peripheral side.
interface gpio_bank_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  MemWrite;
    logic                  MemRead;
    logic [5:0]            addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output MemWrite,
        output MemRead,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  MemWrite,
        input  MemRead,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: multi-flop synchroniser for asynchronous pin inputs.
//   clk   - sampling clock
//   reset - synchronous, active-high; clears every stage to 0
//   din   - asynchronous inputs, WIDTH bits
//   dout  - synchronised copy, STAGES cycles behind din
module gpio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO peripheral on the data-memory bus.
//   clk           - single rising-edge clock
//   reset         - synchronous, active-high; bus accesses in a reset cycle are dropped
//   bus           - gpio_bank_if slave (MemWrite, MemRead, addr, wdata, rdata)
//   gpio_port_in  - asynchronous pin inputs
//   gpio_port_out - DATA_OUT masked by DIR
//   gpio_oe       - output enable, equal to DIR
//   irq           - level interrupt, OR of IRQ_STATUS
// Registers: DATA_IN (RO), DATA_OUT (RW), OUT_SET/CLR/TGL (WO, read 0), DIR, RISE_EN,
// FALL_EN (RW), IRQ_STATUS (RW1C). Only the low GPIO_WIDTH bits are stored.
module gpio_bank #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned GPIO_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    gpio_bank_if.slave            bus,
    input  logic [GPIO_WIDTH-1:0] gpio_port_in,
    output logic [GPIO_WIDTH-1:0] gpio_port_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    import gpio_pkg::*;

    if (!gpio_width_legal(GPIO_WIDTH) || SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_param_check
        $error("gpio_bank: GPIO_WIDTH or SYNC_STAGES out of range");
    end

    logic [GPIO_WIDTH-1:0] data_in;
    logic [GPIO_WIDTH-1:0] prev_q;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;
    logic [GPIO_WIDTH-1:0] irq_events;

    logic [GPIO_WIDTH-1:0] data_out_q,   data_out_d;
    logic [GPIO_WIDTH-1:0] dir_q,        dir_d;
    logic [GPIO_WIDTH-1:0] rise_en_q,    rise_en_d;
    logic [GPIO_WIDTH-1:0] fall_en_q,    fall_en_d;
    logic [GPIO_WIDTH-1:0] irq_status_q, irq_status_d;
    logic [GPIO_WIDTH-1:0] w1c_mask;

    gpio_offset_t          offset;
    logic [GPIO_WIDTH-1:0] wdata_g;
    logic [DATA_WIDTH-1:0] rdata_mux;
    logic                  unused_bus_bits;

    gpio_sync #(
        .WIDTH  (GPIO_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (gpio_port_in),
        .dout  (data_in)
    );

    assign offset          = {bus.addr[5:2], 2'b00};
    assign wdata_g         = bus.wdata[GPIO_WIDTH-1:0];
    // Byte-lane bits and wdata bits above the pin count carry no meaning here.
    assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata};

    // Edge detect on the synchronised value against its one-cycle-delayed copy.
    assign rise       = data_in & ~prev_q;
    assign fall       = ~data_in & prev_q;
    assign irq_events = (rise & rise_en_q) | (fall & fall_en_q);

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        w1c_mask   = '0;
        if (bus.MemWrite) begin
            case (offset)
                GPIO_DATA_OUT:   data_out_d = wdata_g;
                GPIO_OUT_SET:    data_out_d = data_out_q | wdata_g;
                GPIO_OUT_CLR:    data_out_d = data_out_q & ~wdata_g;
                GPIO_OUT_TGL:    data_out_d = data_out_q ^ wdata_g;
                GPIO_DIR:        dir_d      = wdata_g;
                GPIO_RISE_EN:    rise_en_d  = wdata_g;
                GPIO_FALL_EN:    fall_en_d  = wdata_g;
                GPIO_IRQ_STATUS: w1c_mask   = wdata_g;
                default: ;
            endcase
        end
        // New events are ORed in after the clear so a same-cycle set beats the W1C.
        irq_status_d = (irq_status_q & ~w1c_mask) | irq_events;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            irq_status_q <= '0;
            prev_q       <= '0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_status_q <= irq_status_d;
            prev_q       <= data_in;
        end
    end

    // Combinational read so a simultaneous write still returns the pre-write value.
    always_comb begin
        rdata_mux = '0;
        case (offset)
            GPIO_DATA_IN:    rdata_mux = DATA_WIDTH'(data_in);
            GPIO_DATA_OUT:   rdata_mux = DATA_WIDTH'(data_out_q);
            GPIO_DIR:        rdata_mux = DATA_WIDTH'(dir_q);
            GPIO_RISE_EN:    rdata_mux = DATA_WIDTH'(rise_en_q);
            GPIO_FALL_EN:    rdata_mux = DATA_WIDTH'(fall_en_q);
            GPIO_IRQ_STATUS: rdata_mux = DATA_WIDTH'(irq_status_q);
            default: ;
        endcase
    end

    assign bus.rdata     = bus.MemRead ? rdata_mux : '0;
    assign gpio_port_out = data_out_q & dir_q;
    assign gpio_oe       = dir_q;
    assign irq           = |irq_status_q;

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;

    import gpio_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] pins8;
    logic [4:0] pins5;
    logic [7:0] out8, oe8;
    logic [4:0] out5, oe5;
    logic       irq8, irq5;

    int checks = 0;
    int errors = 0;

    gpio_bank_if #(.DATA_WIDTH(32)) bus8 ();
    gpio_bank_if #(.DATA_WIDTH(32)) bus5 ();

    gpio_bank #(.DATA_WIDTH(32), .GPIO_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus8),
        .gpio_port_in  (pins8),
        .gpio_port_out (out8),
        .gpio_oe       (oe8),
        .irq           (irq8)
    );

    gpio_bank #(.DATA_WIDTH(32), .GPIO_WIDTH(5), .SYNC_STAGES(2)) dut5 (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus5),
        .gpio_port_in  (pins5),
        .gpio_port_out (out5),
        .gpio_oe       (oe5),
        .irq           (irq5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
        string       name;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic w8(input logic [5:0] a, input logic [31:0] d);
        bus8.addr = a; bus8.wdata = d; bus8.MemWrite = 1'b1;
        @(posedge clk);
        #1;
        bus8.MemWrite = 1'b0;
    endtask

    task automatic r8(input logic [5:0] a, output logic [31:0] d);
        bus8.addr = a; bus8.MemRead = 1'b1;
        #1;
        d = bus8.rdata;
        bus8.MemRead = 1'b0;
    endtask

    task automatic w5(input logic [5:0] a, input logic [31:0] d);
        bus5.addr = a; bus5.wdata = d; bus5.MemWrite = 1'b1;
        @(posedge clk);
        #1;
        bus5.MemWrite = 1'b0;
    endtask

    task automatic r5(input logic [5:0] a, output logic [31:0] d);
        bus5.addr = a; bus5.MemRead = 1'b1;
        #1;
        d = bus5.rdata;
        bus5.MemRead = 1'b0;
    endtask

    logic [31:0] rd;
    logic [5:0]  off;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, GPIO_DIR,      32'hFF,       32'h0,  8'h00, 8'hFF, "dir_ff"};
        vecs[1]  = '{1'b1, 1'b0, GPIO_DATA_OUT, 32'h0F,       32'h0,  8'h0F, 8'hFF, "out_0f"};
        vecs[2]  = '{1'b1, 1'b0, GPIO_OUT_SET,  32'h30,       32'h0,  8'h3F, 8'hFF, "set_30"};
        vecs[3]  = '{1'b1, 1'b0, GPIO_OUT_CLR,  32'h01,       32'h0,  8'h3E, 8'hFF, "clr_01"};
        vecs[4]  = '{1'b1, 1'b0, GPIO_OUT_TGL,  32'hFF,       32'h0,  8'hC1, 8'hFF, "tgl_ff"};
        vecs[5]  = '{1'b0, 1'b1, GPIO_DATA_OUT, 32'h0,        32'hC1, 8'hC1, 8'hFF, "rd_out_c1"};
        vecs[6]  = '{1'b0, 1'b1, GPIO_OUT_TGL,  32'h0,        32'h0,  8'hC1, 8'hFF, "rd_tgl_wo"};
        vecs[7]  = '{1'b1, 1'b0, GPIO_DIR,      32'h0F,       32'h0,  8'h01, 8'h0F, "dir_0f"};
        vecs[8]  = '{1'b1, 1'b0, GPIO_DATA_OUT, 32'hFF,       32'h0,  8'h0F, 8'h0F, "out_ff_masked"};
        vecs[9]  = '{1'b0, 1'b1, GPIO_DATA_OUT, 32'h0,        32'hFF, 8'h0F, 8'h0F, "rd_out_ff"};
        vecs[10] = '{1'b1, 1'b1, GPIO_DATA_OUT, 32'h123456A5, 32'hFF, 8'h05, 8'h0F, "rdwr_prewrite"};
        vecs[11] = '{1'b0, 1'b1, GPIO_DATA_OUT, 32'h0,        32'hA5, 8'h05, 8'h0F, "rd_out_a5"};
        vecs[12] = '{1'b1, 1'b0, 6'h3C,         32'hFF,       32'h0,  8'h05, 8'h0F, "wr_unmapped"};
        vecs[13] = '{1'b0, 1'b1, 6'h24,         32'h0,        32'h0,  8'h05, 8'h0F, "rd_unmapped"};
        vecs[14] = '{1'b1, 1'b1, GPIO_DIR,      32'hF0,       32'h0F, 8'hA0, 8'hF0, "rdwr_dir"};
        vecs[15] = '{1'b0, 1'b1, 6'h15,         32'h0,        32'hF0, 8'hA0, 8'hF0, "rd_dir_lowbits"};
        vecs[16] = '{1'b1, 1'b0, GPIO_DIR,      32'h00,       32'h0,  8'h00, 8'h00, "dir_00"};

        bus8.MemWrite = 1'b0; bus8.MemRead = 1'b0; bus8.addr = '0; bus8.wdata = '0;
        bus5.MemWrite = 1'b0; bus5.MemRead = 1'b0; bus5.addr = '0; bus5.wdata = '0;

        // Reset for 3 cycles with random pins and a write that must be dropped.
        reset = 1'b1;
        pins8 = 8'($urandom);
        pins5 = 5'($urandom);
        bus8.MemWrite = 1'b1; bus8.addr = GPIO_DIR; bus8.wdata = 32'hFF;
        cycles(3);
        reset = 1'b0;
        bus8.MemWrite = 1'b0;
        check("rst_out8", 32'(out8), 32'h0);
        check("rst_oe8",  32'(oe8),  32'h0);
        check("rst_irq8", 32'(irq8), 32'h0);
        check("rst_out5", 32'(out5), 32'h0);
        check("rst_oe5",  32'(oe5),  32'h0);
        check("rst_irq5", 32'(irq5), 32'h0);
        check("rst_rdata_idle", bus8.rdata, 32'h0);
        r8(GPIO_DATA_IN, rd);
        check("rst_data_in_flushed", rd, 32'h0);
        for (int i = 1; i < 16; i++) begin
            off = 6'(i * 4);
            r8(off, rd);
            check($sformatf("rst_rd8_%02h", off), rd, 32'h0);
            r5(off, rd);
            check($sformatf("rst_rd5_%02h", off), rd, 32'h0);
            cycles(1);
        end

        pins8 = 8'h00;
        pins5 = 5'h00;
        cycles(4);

        // Register-file and output vectors.
        for (int i = 0; i < NVEC; i++) begin
            bus8.addr = vecs[i].addr;
            bus8.wdata = vecs[i].wdata;
            bus8.MemRead = vecs[i].rd;
            bus8.MemWrite = vecs[i].wr;
            #1;
            check({vecs[i].name, "_rdata"}, bus8.rdata, vecs[i].exp_rdata);
            @(posedge clk);
            #1;
            bus8.MemWrite = 1'b0;
            bus8.MemRead = 1'b0;
            check({vecs[i].name, "_out"}, 32'(out8), 32'(vecs[i].exp_out));
            check({vecs[i].name, "_oe"},  32'(oe8),  32'(vecs[i].exp_oe));
        end

        // Rise latency on pin0 with two synchroniser stages.
        w8(GPIO_RISE_EN, 32'hFFFFFF01);
        r8(GPIO_RISE_EN, rd);
        check("rise_en_masked", rd, 32'h01);
        pins8 = 8'h01;
        cycles(1);
        r8(GPIO_DATA_IN, rd);
        check("din_n", rd, 32'h00);
        cycles(1);
        r8(GPIO_DATA_IN, rd);
        check("din_n1", rd, 32'h01);
        r8(GPIO_IRQ_STATUS, rd);
        check("stat_n1", rd, 32'h00);
        check("irq_n1", 32'(irq8), 32'h0);
        cycles(1);
        r8(GPIO_IRQ_STATUS, rd);
        check("stat_n2", rd, 32'h01);
        check("irq_n2", 32'(irq8), 32'h1);
        pins8 = 8'h00;
        cycles(4);
        r8(GPIO_IRQ_STATUS, rd);
        check("stat_fall_ignored", rd, 32'h01);

        // Falling-edge enable on pin1; rise on pin1 alone must not latch.
        w8(GPIO_FALL_EN, 32'h02);
        pins8 = 8'h02;
        cycles(4);
        r8(GPIO_IRQ_STATUS, rd);
        check("stat_rise1_disabled", rd, 32'h01);
        pins8 = 8'h00;
        cycles(4);
        r8(GPIO_IRQ_STATUS, rd);
        check("stat_fall1", rd, 32'h03);
        w8(GPIO_RISE_EN, 32'h00);
        r8(GPIO_IRQ_STATUS, rd);
        check("stat_kept_after_disable", rd, 32'h03);
        w8(GPIO_IRQ_STATUS, 32'h03);
        r8(GPIO_IRQ_STATUS, rd);
        check("stat_w1c_all", rd, 32'h00);
        check("irq_w1c_all", 32'(irq8), 32'h0);

        // W1C colliding with a new enabled rise: set wins.
        w8(GPIO_RISE_EN, 32'h01);
        pins8 = 8'h01;
        cycles(4);
        pins8 = 8'h00;
        cycles(4);
        r8(GPIO_IRQ_STATUS, rd);
        check("coll_pre", rd, 32'h01);
        pins8 = 8'h01;
        cycles(2);
        w8(GPIO_IRQ_STATUS, 32'h01);
        r8(GPIO_IRQ_STATUS, rd);
        check("coll_set_wins", rd, 32'h01);
        check("coll_irq", 32'(irq8), 32'h1);
        cycles(2);
        w8(GPIO_IRQ_STATUS, 32'h01);
        r8(GPIO_IRQ_STATUS, rd);
        check("coll_cleared", rd, 32'h00);
        check("coll_irq_low", 32'(irq8), 32'h0);

        // Five-pin instance: width masking and unmapped writes.
        w5(GPIO_DATA_OUT, 32'hFFFFFFFF);
        r5(GPIO_DATA_OUT, rd);
        check("w5_out_masked", rd, 32'h1F);
        w5(GPIO_DIR, 32'hFFFFFFFF);
        check("w5_pins", 32'(out5), 32'h1F);
        check("w5_oe", 32'(oe5), 32'h1F);
        w5(6'h3C, 32'hFFFFFFFF);
        r5(GPIO_DATA_OUT, rd);
        check("w5_unmapped_out", rd, 32'h1F);
        r5(GPIO_RISE_EN, rd);
        check("w5_unmapped_rise", rd, 32'h00);
        r5(GPIO_FALL_EN, rd);
        check("w5_unmapped_fall", rd, 32'h00);
        cycles(1);
        r5(GPIO_IRQ_STATUS, rd);
        check("w5_unmapped_stat", rd, 32'h00);
        r5(6'h24, rd);
        check("w5_rd_24", rd, 32'h00);

        // Mid-operation reset drops the concurrent write.
        w8(GPIO_DIR, 32'hFF);
        w8(GPIO_DATA_OUT, 32'h55);
        check("pre_rst_out", 32'(out8), 32'h55);
        reset = 1'b1;
        bus8.addr = GPIO_DATA_OUT; bus8.wdata = 32'hAA; bus8.MemWrite = 1'b1;
        cycles(1);
        reset = 1'b0;
        bus8.MemWrite = 1'b0;
        check("midrst_out", 32'(out8), 32'h0);
        check("midrst_oe", 32'(oe8), 32'h0);
        check("midrst_oe5", 32'(oe5), 32'h0);
        r8(GPIO_DATA_OUT, rd);
        check("midrst_data_out", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
